// File: rtl/fb_write_scheduler.sv
// Arbitrates two pixel requesters onto one frame-buffer write port, with a full-frame fill mode.
// Pixel writes land one cycle after the transfer; readies drop during a fill and on a clear request.
module fb_write_scheduler #(
  parameter int W      = 320,
  parameter int H      = 240,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17,
  parameter int X_W    = 9,
  parameter int Y_W    = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [X_W-1:0]    req0_x,
  input  logic [Y_W-1:0]    req0_y,
  input  logic [DATA_W-1:0] req0_color,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [X_W-1:0]    req1_x,
  input  logic [Y_W-1:0]    req1_y,
  input  logic [DATA_W-1:0] req1_color,
  output logic              fb_en,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_din,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // Fill counter is one bit wider than the address so it can hold W*H itself.
  localparam logic [ADDR_W:0] NPIX     = (ADDR_W+1)'(W*H);
  localparam logic [ADDR_W:0] NPIX_M1  = NPIX - 1'b1;
  localparam logic [X_W:0]    W_LIM    = (X_W+1)'(W);
  localparam logic [Y_W:0]    H_LIM    = (Y_W+1)'(H);

  state_t              state_q;
  logic                last_q;
  logic [ADDR_W:0]     cnt_q;
  logic [DATA_W-1:0]   color_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    drop_q;

  logic                accept_ok;
  logic                grant0;
  logic                grant1;
  logic                xfer;
  logic                in_range;
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [DATA_W-1:0]   sel_color;
  logic [ADDR_W-1:0]   pix_addr;

  // last_q = 1 means requester 1 was served last, so requester 0 wins a tie.
  assign accept_ok  = (state_q == IDLE) && !clear_start && !rst;
  assign grant0     = req0_valid && (!req1_valid || last_q);
  assign grant1     = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = accept_ok && grant0;
  assign req1_ready = accept_ok && grant1;
  assign xfer       = req0_ready || req1_ready;

  assign sel_x      = req1_ready ? req1_x     : req0_x;
  assign sel_y      = req1_ready ? req1_y     : req0_y;
  assign sel_color  = req1_ready ? req1_color : req0_color;
  assign in_range   = ({1'b0, sel_x} < W_LIM) && ({1'b0, sel_y} < H_LIM);
  assign pix_addr   = ADDR_W'(sel_y) * ADDR_W'(W) + ADDR_W'(sel_x);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      color_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (clear_start) begin
          state_q <= CLEAR;
          color_q <= clear_color;
          cnt_q   <= (ADDR_W+1)'(1);
          wr_q    <= 1'b1;
          addr_q  <= '0;
          din_q   <= clear_color;
          busy_q  <= 1'b1;
          done_q  <= (NPIX == (ADDR_W+1)'(1));
        end else if (xfer) begin
          last_q <= req1_ready;
          if (in_range) begin
            wr_q   <= 1'b1;
            addr_q <= pix_addr;
            din_q  <= sel_color;
          end else if (drop_q != '1) begin
            drop_q <= drop_q + 1'b1;
          end
        end
      end else begin
        // cnt_q reaching NPIX means the final fill write is on the port this cycle.
        if (cnt_q == NPIX) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end else begin
          wr_q   <= 1'b1;
          addr_q <= cnt_q[ADDR_W-1:0];
          din_q  <= color_q;
          done_q <= (cnt_q == NPIX_M1);
          cnt_q  <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign fb_en      = wr_q;
  assign fb_we      = wr_q;
  assign fb_addr    = addr_q;
  assign fb_din     = din_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench: full-size instance for directed pixel/arbitration cases, small 4x2 instance for fills and random traffic.
module tb_fb_write_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Instance A: default geometry
  logic        rst_a, a_clear_start, a_clear_busy, a_clear_done;
  logic [15:0] a_clear_color;
  logic        a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
  logic [8:0]  a_req0_x, a_req1_x;
  logic [7:0]  a_req0_y, a_req1_y;
  logic [15:0] a_req0_color, a_req1_color;
  logic        a_fb_en, a_fb_we;
  logic [16:0] a_fb_addr;
  logic [15:0] a_fb_din, a_drop_cnt;

  fb_write_scheduler dut_a (
    .clk_sys(clk), .rst(rst_a),
    .clear_start(a_clear_start), .clear_color(a_clear_color),
    .clear_busy(a_clear_busy), .clear_done(a_clear_done),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready),
    .req0_x(a_req0_x), .req0_y(a_req0_y), .req0_color(a_req0_color),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready),
    .req1_x(a_req1_x), .req1_y(a_req1_y), .req1_color(a_req1_color),
    .fb_en(a_fb_en), .fb_we(a_fb_we), .fb_addr(a_fb_addr), .fb_din(a_fb_din),
    .drop_cnt(a_drop_cnt)
  );

  // Instance B: 4x2 frame, 3-bit drop counter so saturation is reachable
  localparam int BW = 4;
  localparam int BH = 2;
  localparam int BN = BW * BH;
  localparam int BDMAX = 7;

  logic        rst_b, b_clear_start, b_clear_busy, b_clear_done;
  logic [15:0] b_clear_color;
  logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [2:0]  b_req0_x, b_req1_x;
  logic [1:0]  b_req0_y, b_req1_y;
  logic [15:0] b_req0_color, b_req1_color;
  logic        b_fb_en, b_fb_we;
  logic [2:0]  b_fb_addr;
  logic [15:0] b_fb_din;
  logic [2:0]  b_drop_cnt;

  fb_write_scheduler #(.W(BW), .H(BH), .DATA_W(16), .ADDR_W(3), .X_W(3), .Y_W(2), .CNT_W(3)) dut_b (
    .clk_sys(clk), .rst(rst_b),
    .clear_start(b_clear_start), .clear_color(b_clear_color),
    .clear_busy(b_clear_busy), .clear_done(b_clear_done),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
    .req0_x(b_req0_x), .req0_y(b_req0_y), .req0_color(b_req0_color),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
    .req1_x(b_req1_x), .req1_y(b_req1_y), .req1_color(b_req1_color),
    .fb_en(b_fb_en), .fb_we(b_fb_we), .fb_addr(b_fb_addr), .fb_din(b_fb_din),
    .drop_cnt(b_drop_cnt)
  );

  // Reference model for instance B: fill is tracked by its start cycle, pixels by a one-deep pending write.
  int          cyc = 0;
  int          fill_t = -1;
  logic [15:0] fill_col = '0;
  bit          last_m = 1'b1;
  int          drop_m = 0;
  bit          pw = 1'b0;
  int          paddr = 0;
  logic [15:0] pdin = '0;

  always @(negedge clk) begin : model
    bit in_fill, exp_en, blk, e0, e1;
    int mx, my;
    cyc++;
    if (rst_b) begin
      chk("b_rst_en",   32'(b_fb_en), 0);
      chk("b_rst_we",   32'(b_fb_we), 0);
      chk("b_rst_addr", 32'(b_fb_addr), 0);
      chk("b_rst_din",  32'(b_fb_din), 0);
      chk("b_rst_busy", 32'(b_clear_busy), 0);
      chk("b_rst_done", 32'(b_clear_done), 0);
      chk("b_rst_drop", 32'(b_drop_cnt), 0);
      chk("b_rst_r0",   32'(b_req0_ready), 0);
      chk("b_rst_r1",   32'(b_req1_ready), 0);
      fill_t = -1; last_m = 1'b1; drop_m = 0; pw = 1'b0;
    end else begin
      in_fill = (fill_t >= 0) && (cyc > fill_t) && (cyc <= fill_t + BN);
      exp_en  = pw || in_fill;
      chk("b_en",   32'(b_fb_en), 32'(exp_en));
      chk("b_we",   32'(b_fb_we), 32'(exp_en));
      chk("b_busy", 32'(b_clear_busy), 32'(in_fill));
      chk("b_done", 32'(b_clear_done), 32'(in_fill && (cyc == fill_t + BN)));
      chk("b_drop", 32'(b_drop_cnt), drop_m);
      if (pw) begin
        chk("b_pix_addr", 32'(b_fb_addr), paddr);
        chk("b_pix_din",  32'(b_fb_din), 32'(pdin));
      end else if (in_fill) begin
        chk("b_fill_addr", 32'(b_fb_addr), cyc - fill_t - 1);
        chk("b_fill_din",  32'(b_fb_din), 32'(fill_col));
      end
      blk = in_fill || b_clear_start;
      e0  = !blk && b_req0_valid && (!b_req1_valid || last_m);
      e1  = !blk && b_req1_valid && (!b_req0_valid || !last_m);
      chk("b_r0", 32'(b_req0_ready), 32'(e0));
      chk("b_r1", 32'(b_req1_ready), 32'(e1));
      pw = 1'b0;
      if (e0 || e1) begin
        mx = e1 ? int'(b_req1_x) : int'(b_req0_x);
        my = e1 ? int'(b_req1_y) : int'(b_req0_y);
        last_m = e1;
        if (mx < BW && my < BH) begin
          pw = 1'b1;
          paddr = my * BW + mx;
          pdin = e1 ? b_req1_color : b_req0_color;
        end else if (drop_m < BDMAX) begin
          drop_m++;
        end
      end
      if (!in_fill && b_clear_start) begin
        fill_t = cyc;
        fill_col = b_clear_color;
      end
    end
  end

  initial begin
    int wr_cnt, dn_cnt, bz_cnt;
    rst_a = 1'b1; rst_b = 1'b1;
    a_clear_start = 1'b0; a_clear_color = '0;
    a_req0_valid = 1'b1; a_req0_x = 9'd5;  a_req0_y = 8'd2; a_req0_color = 16'hF800;
    a_req1_valid = 1'b1; a_req1_x = 9'd10; a_req1_y = 8'd0; a_req1_color = 16'h1234;
    b_clear_start = 1'b0; b_clear_color = '0;
    b_req0_valid = 1'b0; b_req0_x = '0; b_req0_y = '0; b_req0_color = '0;
    b_req1_valid = 1'b0; b_req1_x = '0; b_req1_y = '0; b_req1_color = '0;

    // Reset with both requesters valid
    @(negedge clk);
    chk("a_rst_r0",   32'(a_req0_ready), 0);
    chk("a_rst_r1",   32'(a_req1_ready), 0);
    chk("a_rst_en",   32'(a_fb_en), 0);
    chk("a_rst_we",   32'(a_fb_we), 0);
    chk("a_rst_addr", 32'(a_fb_addr), 0);
    chk("a_rst_din",  32'(a_fb_din), 0);
    chk("a_rst_busy", 32'(a_clear_busy), 0);
    chk("a_rst_done", 32'(a_clear_done), 0);
    chk("a_rst_drop", 32'(a_drop_cnt), 0);

    // Release: req0 first, then alternation; writes follow one cycle later
    @(posedge clk); #1 rst_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("a_arb_r0", 32'(a_req0_ready), 32'(k % 2 == 0));
        chk("a_arb_r1", 32'(a_req1_ready), 32'(k % 2 == 1));
      end
      if (k >= 1) begin
        chk("a_arb_en",   32'(a_fb_en), 1);
        chk("a_arb_we",   32'(a_fb_we), 1);
        chk("a_arb_addr", 32'(a_fb_addr), ((k - 1) % 2 == 0) ? 645 : 10);
        chk("a_arb_din",  32'(a_fb_din), ((k - 1) % 2 == 0) ? 32'h0000F800 : 32'h00001234);
      end
      @(posedge clk); #1;
      if (k == 3) begin a_req0_valid = 1'b0; a_req1_valid = 1'b0; end
    end
    @(negedge clk);
    chk("a_idle_en", 32'(a_fb_en), 0);

    // Out-of-range pixels on requester 1
    @(posedge clk); #1 a_req1_valid = 1'b1; a_req1_x = 9'd320; a_req1_y = 8'd0;
    @(negedge clk);
    chk("a_oor_r1a", 32'(a_req1_ready), 1);
    @(posedge clk); #1 a_req1_x = 9'd0; a_req1_y = 8'd240;
    @(negedge clk);
    chk("a_oor_r1b",  32'(a_req1_ready), 1);
    chk("a_oor_en1",  32'(a_fb_en), 0);
    chk("a_oor_drop1", 32'(a_drop_cnt), 1);
    @(posedge clk); #1 a_req1_valid = 1'b0;
    @(negedge clk);
    chk("a_oor_en2",  32'(a_fb_en), 0);
    chk("a_oor_drop2", 32'(a_drop_cnt), 2);

    // Fill on the 4x2 instance with req0 pending throughout
    @(posedge clk); #1 rst_b = 1'b0;
    @(posedge clk); #1;
    b_clear_start = 1'b1; b_clear_color = 16'h001F;
    b_req0_valid = 1'b1; b_req0_x = 3'd1; b_req0_y = 2'd1; b_req0_color = 16'hAAAA;
    @(negedge clk);
    chk("b_fill_r0_T", 32'(b_req0_ready), 0);
    @(posedge clk); #1 b_clear_start = 1'b0; b_clear_color = 16'hFFFF;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk("b_lit_en",   32'(b_fb_en), 1);
        chk("b_lit_addr", 32'(b_fb_addr), k - 1);
        chk("b_lit_din",  32'(b_fb_din), 32'h0000001F);
        chk("b_lit_done", 32'(b_clear_done), 32'(k == 8));
        chk("b_lit_r0",   32'(b_req0_ready), 0);
      end else begin
        chk("b_lit_r0_end",   32'(b_req0_ready), 1);
        chk("b_lit_busy_end", 32'(b_clear_busy), 0);
      end
      @(posedge clk); #1;
      b_clear_start = (k == 3);
    end
    b_req0_valid = 1'b0;
    @(negedge clk);
    chk("b_lit_pix_addr", 32'(b_fb_addr), 5);
    chk("b_lit_pix_din",  32'(b_fb_din), 32'h0000AAAA);

    // Reset in the middle of a fill
    @(posedge clk); #1 b_clear_start = 1'b1; b_clear_color = 16'h07E0;
    @(posedge clk); #1 b_clear_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_b = 1'b1;
    @(negedge clk);
    chk("b_abort_en",   32'(b_fb_en), 0);
    chk("b_abort_busy", 32'(b_clear_busy), 0);
    @(posedge clk); #1 rst_b = 1'b0;
    wr_cnt = 0; dn_cnt = 0; bz_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b_fb_en) wr_cnt++;
      if (b_clear_done) dn_cnt++;
      if (b_clear_busy) bz_cnt++;
    end
    chk("b_abort_writes", wr_cnt, 0);
    chk("b_abort_done",   dn_cnt, 0);
    chk("b_abort_busy_after", bz_cnt, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst_b         = ($urandom_range(0, 399) == 0);
      b_clear_start = ($urandom_range(0, 29) == 0);
      b_clear_color = 16'($urandom);
      b_req0_valid  = ($urandom_range(0, 3) != 0);
      b_req0_x      = 3'($urandom_range(0, 7));
      b_req0_y      = 2'($urandom_range(0, 3));
      b_req0_color  = 16'($urandom);
      b_req1_valid  = ($urandom_range(0, 3) != 0);
      b_req1_x      = 3'($urandom_range(0, 7));
      b_req1_y      = 2'($urandom_range(0, 3));
      b_req1_color  = 16'($urandom);
    end
    @(posedge clk); #1;
    rst_b = 1'b0; b_clear_start = 1'b0; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning): W 320 frame width in pixels; H 240 frame height in pixels; DATA_W 16 pixel word width; ADDR_W 17 frame-buffer address width; X_W 9 x-coordinate width; Y_W 8 y-coordinate width; CNT_W 16 drop-counter width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk_sys in 1 system clock, all logic rising-edge
- rst in 1 asynchronous active-high reset
- clear_start in 1 one-cycle request to fill the whole frame with clear_color
- clear_color in DATA_W fill colour, sampled on the cycle clear_start is accepted
- clear_busy out 1 high while the fill is in progress
- clear_done out 1 one-cycle pulse on the last fill write
- req0_valid in 1 requester 0 (car renderer) pixel valid
- req0_ready out 1 requester 0 accept
- req0_x in X_W, req0_y in Y_W, req0_color in DATA_W requester 0 pixel
- req1_valid, req1_ready, req1_x, req1_y, req1_color same as requester 0, for requester 1 (background renderer)
- fb_en out 1 frame-buffer write-port enable
- fb_we out 1 frame-buffer write enable
- fb_addr out ADDR_W frame-buffer write address
- fb_din out DATA_W frame-buffer write data
- drop_cnt out CNT_W count of accepted out-of-range pixels

Function
REQ-004 States SHALL be IDLE and CLEAR only.
REQ-005 In IDLE with clear_start low: reqN_ready SHALL be combinational; one valid requester gets ready; if both valid, the one not served last gets ready; the other's ready SHALL be low.
REQ-006 The last-served pointer SHALL update only on a completed transfer (valid && ready).
REQ-007 Readies SHALL be low in CLEAR and in any IDLE cycle with clear_start high (clear wins over pixels in the same cycle).
REQ-008 A transfer in cycle T with x<W and y<H SHALL produce fb_en=fb_we=1, fb_addr=y*W+x, fb_din=color in cycle T+1 (one registered stage).
REQ-009 Address arithmetic SHALL be at least ADDR_W wide with no truncation for in-range coordinates.
REQ-010 A transfer with x>=W or y>=H SHALL be accepted (ready honoured), produce no write, and increment drop_cnt; drop_cnt SHALL saturate at all ones.
REQ-011 clear_start high in IDLE cycle T SHALL latch clear_color and enter CLEAR; clear_busy SHALL be high in cycles T+1..T+W*H.
REQ-012 In CLEAR, one write per cycle SHALL be issued: cycle T+1+k drives fb_addr=k, fb_din=latched colour, fb_en=fb_we=1, for k=0..W*H-1.
REQ-013 clear_done SHALL pulse in cycle T+W*H, coinciding with the write to address W*H-1; the state SHALL return to IDLE so readies may assert in cycle T+W*H+1.
REQ-014 A pixel transfer in cycle T-1 SHALL write in cycle T; no pixel write and fill write SHALL ever occur in the same cycle.
REQ-015 clear_start during CLEAR SHALL be ignored; clear_color changes during CLEAR SHALL not affect the fill.
REQ-016 fb_en and fb_we SHALL always be equal, and both SHALL be low in any cycle with no write.

Reset
REQ-017 On rst high, immediately and asynchronously: state=IDLE, fill counter=0, last-served=requester 1 (requester 0 wins the first tie), drop_cnt=0, fb_en=fb_we=0, fb_addr=0, fb_din=0, clear_busy=0, clear_done=0.
REQ-018 rst asserted mid-fill SHALL abort the fill with no further writes and no clear_done; after release the block SHALL be in IDLE.

Verification
REQ-019 Reset: assert rst, all valid high -> all outputs 0, readies low while rst high; after release, req0 is granted first.
REQ-020 Single pixel: req0 x=5 y=2 color=16'hF800 at T -> req0_ready=1 at T; fb_addr=645, fb_din=16'hF800, fb_en=fb_we=1 at T+1.
REQ-021 Contention: both valid for 4 cycles -> grants in order 0,1,0,1; 4 writes on consecutive cycles.
REQ-022 Out-of-range: req1 x=320 y=0, then x=0 y=240 -> both accepted, no fb_en, drop_cnt=2.
REQ-023 Fill with W=4 H=2, clear_start at T, colour 16'h001F, req0 valid throughout -> addresses 0..7 at T+1..T+8, clear_done at T+8, req0_ready low until T+9.
REQ-024 Fill with W=4 H=2, rst high at T+3 -> no writes from T+3 on, clear_done never pulses, clear_busy=0.
